// File: rtl/ram_sweep_pkg.sv
// Shared types and helpers for the RAM sweep self-test.
// States WRITE_INV/READ_INV are only reachable when RAM_SWEEP_INVERT_EN is defined.
package ram_sweep_pkg;

    localparam int DEF_ADDR_WIDTH = 9;
    localparam int DEF_DATA_WIDTH = 16;
    localparam int SWEEP_MAX_W    = 64;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        WRITE_INV,
        READ_INV,
        DONE
    } sweep_state_e;

    // Address-derived test word; callers zero-extend the address and truncate the result.
    function automatic logic [SWEEP_MAX_W-1:0] sweep_expected(
        input logic [SWEEP_MAX_W-1:0] addr,
        input logic [SWEEP_MAX_W-1:0] pattern
    );
        return addr ^ pattern;
    endfunction

endpackage

// File: rtl/ram_sweep_tester_if.sv
// Hack-style RAM port bundle (in, load, address, out) between the sweep tester and a RAM.
interface ram_sweep_tester_if #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] mem_in;
    logic                  mem_load;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [DATA_WIDTH-1:0] mem_out;

    modport master (output mem_in, output mem_load, output mem_address, input mem_out);
    modport slave  (input mem_in, input mem_load, input mem_address, output mem_out);
endinterface

// File: rtl/ram_sweep_addr_counter.sv
// Sweep address counter; wraps naturally from all-ones to zero.
module ram_sweep_addr_counter #(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             last
);
    always_ff @(posedge clk) begin
        if (reset || clr)
            count <= '0;
        else if (en)
            count <= count + WIDTH'(1);
    end

    assign last = (count == '1);
endmodule

// File: rtl/ram_sweep_tester.sv
// Built-in self-test initiator: writes an address pattern to every RAM word, reads it back.
// Define RAM_SWEEP_INVERT_EN to add a second write/read pass with the inverted pattern.
module ram_sweep_tester
    import ram_sweep_pkg::*;
#(
    parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] PATTERN    = '0
) (
    input  logic                    CLK,
    input  logic                    reset,
    input  logic                    start,
    ram_sweep_tester_if.master      mem,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [ADDR_WIDTH+1:0]   err_count,
    output logic [ADDR_WIDTH-1:0]   first_err_addr
);
    localparam int ERR_W = ADDR_WIDTH + 2;

    sweep_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  addr_last;
    logic                  cnt_clr, cnt_en;
    logic                  compare, mismatch;
    logic                  first_seen;
    logic [DATA_WIDTH-1:0] exp_word, exp_cur;

    ram_sweep_addr_counter #(.WIDTH(ADDR_WIDTH)) u_addr_counter (
        .clk   (CLK),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .count (addr),
        .last  (addr_last)
    );

    assign exp_word = DATA_WIDTH'(sweep_expected(SWEEP_MAX_W'(addr), SWEEP_MAX_W'(PATTERN)));

    always_comb begin
        state_d         = state_q;
        cnt_clr         = 1'b0;
        cnt_en          = 1'b0;
        compare         = 1'b0;
        exp_cur         = exp_word;
        mem.mem_load    = 1'b0;
        mem.mem_in      = '0;
        mem.mem_address = '0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = WRITE;
                    cnt_clr = 1'b1;
                end
            end
            WRITE: begin
                mem.mem_load    = 1'b1;
                mem.mem_address = addr;
                mem.mem_in      = exp_word;
                cnt_en          = 1'b1;
                if (addr_last) state_d = READ;
            end
            READ: begin
                mem.mem_address = addr;
                compare         = 1'b1;
                cnt_en          = 1'b1;
`ifdef RAM_SWEEP_INVERT_EN
                if (addr_last) state_d = WRITE_INV;
`else
                if (addr_last) state_d = DONE;
`endif
            end
`ifdef RAM_SWEEP_INVERT_EN
            WRITE_INV: begin
                mem.mem_load    = 1'b1;
                mem.mem_address = addr;
                mem.mem_in      = ~exp_word;
                cnt_en          = 1'b1;
                if (addr_last) state_d = READ_INV;
            end
            READ_INV: begin
                mem.mem_address = addr;
                exp_cur         = ~exp_word;
                compare         = 1'b1;
                cnt_en          = 1'b1;
                if (addr_last) state_d = DONE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    assign mismatch = compare && (mem.mem_out != exp_cur);

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q        <= IDLE;
            err_count      <= '0;
            first_err_addr <= '0;
            first_seen     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (cnt_clr) begin
                err_count      <= '0;
                first_err_addr <= '0;
                first_seen     <= 1'b0;
            end else if (mismatch) begin
                if (err_count != '1)
                    err_count <= err_count + ERR_W'(1);
                // Only the earliest failing address of the whole sweep is kept.
                if (!first_seen) begin
                    first_err_addr <= addr;
                    first_seen     <= 1'b1;
                end
            end
        end
    end

    assign busy = (state_q != IDLE) && (state_q != DONE);
    assign done = (state_q == DONE);
    assign pass = done && (err_count == '0);
endmodule

// File: tb/tb_ram_sweep_tester.sv
// Self-checking bench for ram_sweep_tester against a faulty-RAM model and a sweep-outcome model.
module tb_ram_sweep_tester;
    localparam int AW    = 9;
    localparam int DW    = 16;
    localparam int DEPTH = 1 << AW;
    localparam logic [DW-1:0] PAT = '0;
`ifdef RAM_SWEEP_INVERT_EN
    localparam int PASSES = 2;
`else
    localparam int PASSES = 1;
`endif
    localparam int SWEEP_CYC = 2 * PASSES * DEPTH;
    localparam int LIMIT     = SWEEP_CYC + 64;

    logic          CLK = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          busy, done, pass;
    logic [AW+1:0] err_count;
    logic [AW-1:0] first_err_addr;

    logic [DW-1:0] ram [DEPTH];
    logic [DW-1:0] s0  [DEPTH];
    logic [DW-1:0] s1  [DEPTH];

    int tests = 0;
    int fails = 0;

    always #5 CLK = ~CLK;

    ram_sweep_tester_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    ram_sweep_tester #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PATTERN(PAT)) dut (
        .CLK            (CLK),
        .reset          (reset),
        .start          (start),
        .mem            (bus),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_count      (err_count),
        .first_err_addr (first_err_addr)
    );

    // RAM with per-address stuck-at-0 / stuck-at-1 masks on the read path
    assign bus.mem_out = (ram[bus.mem_address] & ~s0[bus.mem_address]) | s1[bus.mem_address];
    always @(posedge CLK) if (bus.mem_load) ram[bus.mem_address] <= bus.mem_in;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_faults();
        for (int i = 0; i < DEPTH; i++) begin
            s0[i] = '0;
            s1[i] = '0;
        end
    endtask

    // Outcome of a full sweep derived from the fault masks alone.
    function automatic void model(output int err, output int first, output bit ok);
        bit seen = 0;
        logic [DW-1:0] w, rd;
        err = 0;
        first = 0;
        for (int p = 0; p < PASSES; p++)
            for (int a = 0; a < DEPTH; a++) begin
                w = DW'(a) ^ PAT;
                if (p == 1) w = ~w;
                rd = (w & ~s0[a]) | s1[a];
                if (rd != w) begin
                    if (!seen) begin
                        first = a;
                        seen = 1;
                    end
                    if (err < (1 << (AW + 2)) - 1) err++;
                end
            end
        ok = (err == 0);
    endfunction

    task automatic run_sweep(input int glitch_at, output int cyc);
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        check("start_clears_err", err_count, 0);
        check("start_clears_first", first_err_addr, 0);
        check("start_done_low", done, 0);
        for (int n = 0; n < LIMIT && !done; n++) begin
            if (busy) cyc++;
            start = (cyc == glitch_at);
            tick();
            start = 1'b0;
        end
        check("sweep_done", done, 1);
        check("busy_cycles", cyc, SWEEP_CYC);
        check("busy_low_in_done", busy, 0);
    endtask

    typedef struct {
        string         name;
        int            fa0;
        logic [DW-1:0] s0a, s1a;
        int            fa1;
        logic [DW-1:0] s0b, s1b;
        int            e_err;
        int            e_first;
        bit            e_pass;
    } vec_t;

    vec_t vecs[4];

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, m_err, m_first;
        bit m_ok;

        vecs[0] = '{"healthy",    0,     16'h0000, 16'h0000, 0,     16'h0000, 16'h0000, 0, 0,     1'b1};
        vecs[1] = '{"bit0_at_1a3", 'h1A3, 16'h0001, 16'h0000, 0,     16'h0000, 16'h0000, 1, 'h1A3, 1'b0};
        vecs[2] = '{"two_faults", 'h010, 16'h0000, 16'h0001, 'h1FF, 16'h0001, 16'h0000, 2, 'h010, 1'b0};
`ifdef RAM_SWEEP_INVERT_EN
        vecs[3] = '{"bit15_at_0", 0,     16'h8000, 16'h0000, 0,     16'h0000, 16'h0000, 1, 0,     1'b0};
`else
        vecs[3] = '{"bit15_at_0", 0,     16'h8000, 16'h0000, 0,     16'h0000, 16'h0000, 0, 0,     1'b1};
`endif

        for (int i = 0; i < DEPTH; i++) ram[i] = '0;
        clear_faults();

        reset = 1'b1;
        repeat (3) tick();
        check("rst_load", bus.mem_load, 0);
        check("rst_in", bus.mem_in, 0);
        check("rst_addr", bus.mem_address, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_err", err_count, 0);
        check("rst_first", first_err_addr, 0);
        reset = 1'b0;
        tick();

        for (int v = 0; v < 4; v++) begin
            clear_faults();
            s0[vecs[v].fa0] |= vecs[v].s0a;
            s1[vecs[v].fa0] |= vecs[v].s1a;
            s0[vecs[v].fa1] |= vecs[v].s0b;
            s1[vecs[v].fa1] |= vecs[v].s1b;
            run_sweep(-1, cyc);
            check($sformatf("%s_err", vecs[v].name), err_count, vecs[v].e_err);
            check($sformatf("%s_first", vecs[v].name), first_err_addr, vecs[v].e_first);
            check($sformatf("%s_pass", vecs[v].name), pass, vecs[v].e_pass);
            if (v == 0) begin
`ifdef RAM_SWEEP_INVERT_EN
                check("ram5", ram[5], 16'hFFFA);
                check("ram511", ram[511], 16'hFE00);
`else
                check("ram5", ram[5], 16'h0005);
                check("ram511", ram[511], 16'h01FF);
`endif
                check("done_addr", bus.mem_address, 0);
                check("done_load", bus.mem_load, 0);
            end
        end

        // reset in the middle of the write pass
        clear_faults();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (100) tick();
        check("mid_addr", bus.mem_address, 100);
        check("mid_load", bus.mem_load, 1);
        check("mid_wdata", bus.mem_in, 100);
        reset = 1'b1;
        tick();
        check("mid_rst_load", bus.mem_load, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        reset = 1'b0;
        tick();
        run_sweep(-1, cyc);
        check("after_rst_pass", pass, 1);

        // start while busy is ignored
        run_sweep(300, cyc);
        check("glitch_pass", pass, 1);

        // failing sweep, then restart from DONE with a healthy RAM
        s0['h1A3] = 16'h0001;
        run_sweep(-1, cyc);
        check("fail_pass", pass, 0);
        check("fail_err", err_count, 1);
        clear_faults();
        run_sweep(-1, cyc);
        check("restart_pass", pass, 1);
        check("restart_err", err_count, 0);

        // reset clears the result registers
        s0['h044] = 16'h0004;
        run_sweep(-1, cyc);
        check("pre_rst_err", err_count, 1);
        reset = 1'b1;
        tick();
        check("rst_clr_err", err_count, 0);
        check("rst_clr_first", first_err_addr, 0);
        check("rst_clr_done", done, 0);
        reset = 1'b0;
        tick();

        // randomized fault sets against the outcome model
        for (int r = 0; r < 6; r++) begin
            int nf;
            clear_faults();
            nf = $urandom_range(1, 8);
            for (int f = 0; f < nf; f++) begin
                int a;
                logic [DW-1:0] b;
                a = $urandom_range(0, DEPTH - 1);
                b = DW'(1) << $urandom_range(0, DW - 1);
                if ($urandom_range(0, 1) == 1) s0[a] |= b;
                else                           s1[a] |= b;
            end
            model(m_err, m_first, m_ok);
            run_sweep(-1, cyc);
            check($sformatf("rnd%0d_err", r), err_count, m_err);
            check($sformatf("rnd%0d_first", r), first_err_addr, m_first);
            check($sformatf("rnd%0d_pass", r), pass, m_ok);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
